// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, default parameters and width helper for the PISO scheduler
//   no ports; imported by piso_tx_sched_if, piso_shifter and piso_tx_sched
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIV = 4;
    localparam int DEF_GAP_BITS = 1;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEF_GID_W = cw(DEF_NUM_REQ);
    localparam int DEF_BIT_W = cw(DEF_DATA_W);
    localparam int DEF_DIV_W = cw(DEF_DIV);
endpackage

// File: rtl/piso_tx_sched_if.sv
// piso_tx_sched_if: requester handshake and serial output bundle
//   req_valid/req_data/req_ready : per-requester valid/ready word transfer
//   ser_out/ser_en/ser_sof       : serial bit, data-bit strobe, first-bit marker
//   grant_id/busy                : owner of current/last frame, frame-in-progress
//   master = requester/pin side, slave = scheduler side
interface piso_tx_sched_if import piso_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      ser_out;
    logic                      ser_en;
    logic                      ser_sof;
    logic [cw(NUM_REQ)-1:0]    grant_id;
    logic                      busy;
    modport master (
        output req_valid, req_data,
        input  req_ready, ser_out, ser_en, ser_sof, grant_id, busy
    );
    modport slave (
        input  req_valid, req_data,
        output req_ready, ser_out, ser_en, ser_sof, grant_id, busy
    );
endinterface

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-load, right-shifting register with zero fill, LSB out
//   clk, rst (async active-low) ; load/data_in : parallel load ; shift_en : shift right ; sout : bit 0
module piso_shifter import piso_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              sout
);
    logic [DATA_W-1:0] sr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else if (load) sr <= data_in;
        else if (shift_en) sr <= {1'b0, sr[DATA_W-1:1]};
    end
    assign sout = sr[0];
endmodule

// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler sharing one PISO shifter among NUM_REQ word producers
//   clk, rst (async active-low)
//   bus (slave): req_valid/req_data in, one-hot req_ready out (IDLE only),
//                ser_out/ser_en/ser_sof serial stream LSB first, grant_id, busy
module piso_tx_sched import piso_pkg::*; #(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DIV      = DEF_DIV,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input logic            clk,
    input logic            rst,
    piso_tx_sched_if.slave bus
);
    localparam int GID_W   = cw(NUM_REQ);
    localparam int BIT_W   = cw(DATA_W);
    localparam int DIV_W   = cw(DIV);
    localparam int GAP_CYC = GAP_BITS * DIV;
    localparam int GAP_W   = cw(GAP_CYC);
    state_t            state;
    logic [GID_W-1:0]  rr_ptr, win, idx, win_nxt, grant_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] word;
    logic              found, div_last, bit_last, gap_last, sout;
    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == GID_W'(i)) word = bus.req_data[i*DATA_W +: DATA_W];
    end
    assign win_nxt  = (win == GID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign div_last = div_cnt == DIV_W'(DIV - 1);
    assign bit_last = bit_cnt == BIT_W'(DATA_W - 1);
    assign gap_last = gap_cnt == GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state   <= SHIFT;
                    grant_q <= win;
                    rr_ptr  <= win_nxt;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                end
                SHIFT: begin
                    div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                    if (div_last) begin
                        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                        if (bit_last) state <= (GAP_BITS > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
                    if (gap_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    piso_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE && found),
        .shift_en (state == SHIFT && div_last),
        .data_in  (word),
        .sout     (sout)
    );
    // rst gates ready so the grant vanishes the moment reset asserts
    assign bus.req_ready = (rst && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    assign bus.ser_en    = state == SHIFT;
    assign bus.ser_out   = (state == SHIFT) && sout;
    assign bus.ser_sof   = (state == SHIFT) && bit_cnt == '0;
    assign bus.busy      = state != IDLE;
    assign bus.grant_id  = grant_q;
endmodule
